// File: rtl/arb_pkg.sv
// Shared types and default sizing for the arbiter / grant-mux pair.
package arb_pkg;

   localparam int ARB_N  = 32;
   localparam int ARB_DW = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index converter with an exactly-one-bit-set flag.
module onehot_to_bin
   import arb_pkg::*;
#(
   parameter  int N  = ARB_N,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          onehot_ok
);

   always_comb begin
      idx = '0;
      // OR-ing every set position keeps this a flat OR tree; only meaningful when onehot_ok
      for (int unsigned k = 0; k < N; k++) begin
         if (onehot[k]) begin
            idx = idx | IW'(k);
         end
      end
      onehot_ok = (onehot != '0) && ((onehot & (onehot - N'(1))) == '0);
   end

endmodule

// File: rtl/arb_grant_mux.sv
// Grant-driven packet mux: forwards the arbiter's winner through a registered
// output slice, holding the grant until the packet's last beat.
module arb_grant_mux
   import arb_pkg::*;
#(
   parameter  int N  = ARB_N,
   parameter  int DW = ARB_DW,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_valid_i,
   input  logic [N*DW-1:0] req_data_i,
   input  logic [N-1:0]    req_last_i,
   output logic [N-1:0]    req_ready_o,
   output logic [N-1:0]    arb_req_o,
   input  logic [N-1:0]    arb_gnt_i,
   output logic            out_valid_o,
   output logic [DW-1:0]   out_data_o,
   output logic            out_last_o,
   output logic [IW-1:0]   out_id_o,
   input  logic            out_ready_i,
   output logic            err_o
);

   arb_state_t    state;
   logic [IW-1:0] owner;
   logic [IW-1:0] gnt_idx;
   logic          gnt_onehot;
   logic          load;
   logic          gnt_bad;
   logic          xfer;
   logic [IW-1:0] sel;
   logic [DW-1:0] sel_data;
   logic          sel_last;

   onehot_to_bin #(.N(N)) u_gnt_dec (
      .onehot    (arb_gnt_i),
      .idx       (gnt_idx),
      .onehot_ok (gnt_onehot)
   );

   assign load = !out_valid_o || out_ready_i;

   always_comb begin
      sel         = (state == LOCKED) ? owner : gnt_idx;
      sel_data    = req_data_i[int'(sel)*DW +: DW];
      sel_last    = req_last_i[sel];
      gnt_bad     = 1'b0;
      xfer        = 1'b0;
      arb_req_o   = '0;
      req_ready_o = '0;
      if (reset) begin
         if (state == IDLE) begin
            arb_req_o = load ? req_valid_i : '0;
            // a grant that is not one-hot or names an idle requester is rejected outright
            if (load && (arb_gnt_i != '0)) begin
               gnt_bad = !gnt_onehot || ((arb_gnt_i & ~req_valid_i) != '0);
               xfer    = !gnt_bad;
            end
         end else begin
            xfer = load && req_valid_i[owner];
         end
         if (xfer) begin
            req_ready_o[sel] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         out_id_o    <= '0;
         err_o       <= 1'b0;
      end else begin
         if (gnt_bad) begin
            err_o <= 1'b1;
         end
         if (load) begin
            out_valid_o <= xfer;
            if (xfer) begin
               out_data_o <= sel_data;
               out_last_o <= sel_last;
               out_id_o   <= sel;
            end
         end
         if (xfer) begin
            case (state)
               IDLE: begin
                  if (!sel_last) begin
                     state <= LOCKED;
                     owner <= sel;
                  end
               end
               LOCKED: begin
                  if (sel_last) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arb_grant_mux.sv
// Bench for arb_grant_mux (N=4): directed vector table plus randomized run
// against a packet-level reference model, with a lowest-index-wins arbiter.
module tb_arb_grant_mux;

   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  vld, lst, rdy, arq, gnt;
   logic [31:0]   dat;
   logic          ordy, ov, ol, err;
   logic [7:0]    od;
   logic [1:0]    oid;
   logic          fen;
   logic [N-1:0]  fgnt;

   int tests = 0;
   int fails = 0;

   arb_grant_mux #(.N(N), .DW(DW)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .req_valid_i (vld),
      .req_data_i  (dat),
      .req_last_i  (lst),
      .req_ready_o (rdy),
      .arb_req_o   (arq),
      .arb_gnt_i   (gnt),
      .out_valid_o (ov),
      .out_data_o  (od),
      .out_last_o  (ol),
      .out_id_o    (oid),
      .out_ready_i (ordy),
      .err_o       (err)
   );

   // fixed-priority arbiter stand-in, overridable to inject bad grants
   always_comb gnt = fen ? fgnt : (arq & (~arq + 4'd1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         rst;
      logic [3:0]   vld, lst;
      logic [31:0]  dat;
      logic         ordy, fen;
      logic [3:0]   fgnt;
      logic [3:0]   e_rdy, e_arq;
      logic         e_ov;
      logic [7:0]   e_od;
      logic         e_ol;
      logic [1:0]   e_id;
      logic         e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                               logic o, logic fe, logic [3:0] fg, logic [3:0] er,
                               logic [3:0] ea, logic eov, logic [7:0] eod, logic eol,
                               logic [1:0] eid, logic eerr);
      vec_t t;
      t.rst = r; t.vld = v; t.lst = l; t.dat = d; t.ordy = o; t.fen = fe; t.fgnt = fg;
      t.e_rdy = er; t.e_arq = ea; t.e_ov = eov; t.e_od = eod; t.e_ol = eol;
      t.e_id = eid; t.e_err = eerr;
      return t;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // reference model state: lock owner (-1 = none) and output registers
   int         m_lock;
   logic       m_ov, m_ol, m_err;
   logic [7:0] m_od;
   logic [1:0] m_id;

   initial begin
      rst_n = 1'b0; vld = '0; lst = '0; dat = '0; ordy = 1'b1; fen = 1'b0; fgnt = '0;

      //                rst  vld      lst      dat           ordy fen fgnt     e_rdy    e_arq    ov od     ol id err
      // reset with all requesters valid
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0));
      // single-beat contention, req 1 then req 3
      vecs.push_back(mk(1, 4'b1010, 4'b1111, 32'h44332211, 1, 0, 4'b0000, 4'b0010, 4'b1010, 1, 8'h22, 1, 1, 0));
      vecs.push_back(mk(1, 4'b1000, 4'b1111, 32'h44332211, 1, 0, 4'b0000, 4'b1000, 4'b1000, 1, 8'h44, 1, 3, 0));
      vecs.push_back(mk(1, 4'b0000, 4'b1111, 32'h44332211, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h44, 1, 3, 0));
      // packet lock on req 2 (A,B,C), req 0 waiting from B, backpressure before C
      vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h00A10005, 1, 0, 4'b0000, 4'b0100, 4'b0100, 1, 8'hA1, 0, 2, 0));
      vecs.push_back(mk(1, 4'b0101, 4'b0001, 32'h00B20005, 1, 0, 4'b0000, 4'b0100, 4'b0000, 1, 8'hB2, 0, 2, 0));
      vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00C30005, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 8'hB2, 0, 2, 0));
      vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00C30005, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 8'hB2, 0, 2, 0));
      vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00C30005, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 8'hB2, 0, 2, 0));
      vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00C30005, 1, 0, 4'b0000, 4'b0100, 4'b0000, 1, 8'hC3, 1, 2, 0));
      vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h00000005, 1, 0, 4'b0000, 4'b0001, 4'b0001, 1, 8'h05, 1, 0, 0));
      // owner bubble: req 3 locks, drops valid 2 cycles while req 1 waits
      vecs.push_back(mk(1, 4'b1000, 4'b0000, 32'hD0000000, 1, 0, 4'b0000, 4'b1000, 4'b1000, 1, 8'hD0, 0, 3, 0));
      vecs.push_back(mk(1, 4'b0010, 4'b0010, 32'h00001100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'hD0, 0, 3, 0));
      vecs.push_back(mk(1, 4'b0010, 4'b0010, 32'h00001100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'hD0, 0, 3, 0));
      vecs.push_back(mk(1, 4'b1010, 4'b1010, 32'hD2001100, 1, 0, 4'b0000, 4'b1000, 4'b0000, 1, 8'hD2, 1, 3, 0));
      vecs.push_back(mk(1, 4'b0010, 4'b0010, 32'h00001100, 1, 0, 4'b0000, 4'b0010, 4'b0010, 1, 8'h11, 1, 1, 0));
      // multi-bit grant: no transfer, sticky error
      vecs.push_back(mk(1, 4'b0011, 4'b0011, 32'h00002A1B, 1, 1, 4'b0011, 4'b0000, 4'b0011, 0, 8'h11, 1, 1, 1));
      vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h00002A1B, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h11, 1, 1, 1));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0));
      // grant to a non-requesting index
      vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h00000007, 1, 1, 4'b0100, 4'b0000, 4'b0001, 0, 8'h00, 0, 0, 1));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst; vld = vecs[i].vld; lst = vecs[i].lst; dat = vecs[i].dat;
         ordy = vecs[i].ordy; fen = vecs[i].fen; fgnt = vecs[i].fgnt;
         #1;
         check($sformatf("vec%0d ready", i), 32'(rdy), 32'(vecs[i].e_rdy));
         check($sformatf("vec%0d arb_req", i), 32'(arq), 32'(vecs[i].e_arq));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out{v,d,l,id}", i), 32'({ov, od, ol, oid}),
               32'({vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ol, vecs[i].e_id}));
         check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e_err));
      end

      // randomized run against the packet-level model
      fen = 1'b0;
      m_lock = -1; m_ov = 0; m_od = '0; m_ol = 0; m_id = '0; m_err = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] e_rdy, e_arq;
         logic       ld;
         int         k;
         rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         vld   = 4'($urandom | $urandom);
         lst   = 4'($urandom & $urandom);
         dat   = $urandom;
         ordy  = ($urandom_range(0, 3) != 0);
         e_rdy = '0; e_arq = '0; k = -1;
         ld    = !m_ov || ordy;
         if (rst_n) begin
            if (m_lock < 0) begin
               if (ld) e_arq = vld;
               for (int j = N - 1; j >= 0; j--) begin
                  if (e_arq[j]) k = j;
               end
            end else if (ld && vld[m_lock]) begin
               k = m_lock;
            end
            if (k >= 0) e_rdy[k] = 1'b1;
         end
         #1;
         check($sformatf("rnd%0d ready", c), 32'(rdy), 32'(e_rdy));
         check($sformatf("rnd%0d arb_req", c), 32'(arq), 32'(e_arq));
         @(posedge clk);
         if (!rst_n) begin
            m_lock = -1; m_ov = 0; m_od = '0; m_ol = 0; m_id = '0; m_err = 0;
         end else begin
            if (ld) begin
               m_ov = (k >= 0);
               if (k >= 0) begin
                  m_od = dat[k*DW +: DW];
                  m_ol = lst[k];
                  m_id = 2'(k);
               end
            end
            if (k >= 0) begin
               if (m_lock < 0 && !lst[k]) m_lock = k;
               else if (m_lock >= 0 && lst[k]) m_lock = -1;
            end
         end
         #1;
         check($sformatf("rnd%0d out{v,d,l,id,err}", c), 32'({ov, od, ol, oid, err}),
               32'({m_ov, m_od, m_ol, m_id, m_err}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
